vend_change_dispenser: RTL and testbench

Change payout unit on the output side of the vending machine. It accepts the change amount the vending machine reports at the end of a sale and pays it out as physical coins. Coins are requested one at a time from a two-tube coin hopper over a req/ack handshake, largest coin first. It reports completion, reports any shortfall when the tubes cannot cover the amount, and buffers one further change request that arrives while a payout is in progress.

---
 rtl/vend_pkg.sv | 18 +
 rtl/vend_ack_watchdog.sv | 33 +++
 rtl/vend_change_dispenser.sv | 197 +++++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change dispenser.
package vend_pkg;

  localparam int AMT_W = 3;

  localparam logic [1:0] HOP_BIG  = 2'b10;
  localparam logic [1:0] HOP_UNIT = 2'b01;
  localparam logic [1:0] HOP_NONE = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/vend_ack_watchdog.sv
// Loadable down-counter that flags a hopper that never acknowledges.
// Only instantiated when VEND_CHANGE_TIMEOUT_EN is defined.
module vend_ack_watchdog #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(ACK_TIMEOUT);
    end else if (en && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Loaded with ACK_TIMEOUT on entry, so the last count is seen in the ACK_TIMEOUT-th waiting cycle.
  assign expire = en && (count_reg == CW'(1));

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays out change one coin at a time from a two-tube hopper, biggest coin first.
// Optional ack watchdog / err_timeout enabled by defining VEND_CHANGE_TIMEOUT_EN.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int BIG_COIN    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change,
  output logic [1:0]       hop_req,
  input  logic             hop_ack,
  input  logic [1:0]       tube_empty,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] owed,
  output logic             err_short,
  output logic             err_timeout,
  output logic             pend_ovf
);

  localparam logic [AMT_W-1:0] BIG_VAL  = AMT_W'(BIG_COIN);
  localparam logic [AMT_W-1:0] UNIT_VAL = AMT_W'(1);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] remaining_reg, remaining_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [AMT_W-1:0] pend_amt_reg, pend_amt_next;
  logic [1:0]       hop_req_reg, hop_req_next;
  logic [AMT_W-1:0] owed_reg, owed_next;
  logic             err_short_reg, err_short_next;
  logic             busy_reg, done_reg, pend_ovf_reg, pend_ovf_next;
  logic             load_amount;
  logic             strobe;
  logic             timeout_hit;

  assign strobe = change_valid && (change != '0);

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    pend_valid_next = pend_valid_reg;
    pend_amt_next   = pend_amt_reg;
    hop_req_next    = hop_req_reg;
    owed_next       = owed_reg;
    err_short_next  = err_short_reg;
    pend_ovf_next   = 1'b0;
    load_amount     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          load_amount     = 1'b1;
          remaining_next  = pend_amt_reg;
          pend_valid_next = 1'b0;
          state_next      = SELECT;
          // The slot frees up this cycle, so a simultaneous strobe takes its place.
          if (strobe) begin
            pend_valid_next = 1'b1;
            pend_amt_next   = change;
          end
        end else if (change_valid) begin
          if (change != '0) begin
            load_amount    = 1'b1;
            remaining_next = change;
            state_next     = SELECT;
          end else begin
            state_next = DONE;
          end
        end
      end
      SELECT: begin
        if (remaining_reg == '0) begin
          state_next = DONE;
        end else if (remaining_reg >= BIG_VAL && !tube_empty[1]) begin
          hop_req_next = HOP_BIG;
          state_next   = WAIT_ACK;
        end else if (!tube_empty[0]) begin
          hop_req_next = HOP_UNIT;
          state_next   = WAIT_ACK;
        end else begin
          err_short_next = 1'b1;
          owed_next      = remaining_reg;
          state_next     = ERROR;
        end
      end
      WAIT_ACK: begin
        if (hop_ack) begin
          remaining_next = remaining_reg - ((hop_req_reg == HOP_BIG) ? BIG_VAL : UNIT_VAL);
          hop_req_next   = HOP_NONE;
          state_next     = SELECT;
        end else if (timeout_hit) begin
          owed_next    = remaining_reg;
          hop_req_next = HOP_NONE;
          state_next   = ERROR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      ERROR: begin
        hop_req_next = HOP_NONE;
        state_next   = IDLE;
      end
      default: begin
        hop_req_next = HOP_NONE;
        state_next   = IDLE;
      end
    endcase

    if (state_reg != IDLE && strobe) begin
      if (!pend_valid_reg) begin
        pend_valid_next = 1'b1;
        pend_amt_next   = change;
      end else begin
        pend_ovf_next = 1'b1;
      end
    end

    if (load_amount) begin
      err_short_next = 1'b0;
      owed_next      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      pend_valid_reg <= 1'b0;
      pend_amt_reg   <= '0;
      hop_req_reg    <= HOP_NONE;
      owed_reg       <= '0;
      err_short_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pend_ovf_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      pend_valid_reg <= pend_valid_next;
      pend_amt_reg   <= pend_amt_next;
      hop_req_reg    <= hop_req_next;
      owed_reg       <= owed_next;
      err_short_reg  <= err_short_next;
      busy_reg       <= (state_next != IDLE);
      done_reg       <= (state_next == DONE);
      pend_ovf_reg   <= pend_ovf_next;
    end
  end

`ifdef VEND_CHANGE_TIMEOUT_EN
  logic wd_load, wd_clear, wd_en, set_timeout;
  logic err_timeout_reg;

  assign wd_load     = (state_reg == SELECT) && (state_next == WAIT_ACK);
  assign wd_clear    = (state_next != WAIT_ACK);
  assign wd_en       = (state_reg == WAIT_ACK);
  assign set_timeout = (state_reg == WAIT_ACK) && timeout_hit && !hop_ack;

  vend_ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .load  (wd_load),
    .clear (wd_clear),
    .en    (wd_en),
    .expire(timeout_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_timeout_reg <= 1'b0;
    end else if (load_amount) begin
      err_timeout_reg <= 1'b0;
    end else if (set_timeout) begin
      err_timeout_reg <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign hop_req   = hop_req_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign owed      = owed_reg;
  assign err_short = err_short_reg;
  assign pend_ovf  = pend_ovf_reg;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed test of vend_change_dispenser; inputs driven and outputs sampled on the falling edge.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       change_valid = 1'b0;
  logic [2:0] change = 3'd0;
  logic [1:0] hop_req;
  logic       hop_ack = 1'b0;
  logic [1:0] tube_empty = 2'b00;
  logic       busy;
  logic       done;
  logic [2:0] owed;
  logic       err_short;
  logic       err_timeout;
  logic       pend_ovf;

  int errors = 0;
  int checks = 0;

  vend_change_dispenser #(
    .BIG_COIN(2),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .change_valid(change_valid),
    .change      (change),
    .hop_req     (hop_req),
    .hop_ack     (hop_ack),
    .tube_empty  (tube_empty),
    .busy        (busy),
    .done        (done),
    .owed        (owed),
    .err_short   (err_short),
    .err_timeout (err_timeout),
    .pend_ovf    (pend_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, got, $time);
    end
  endtask

  task automatic strobe(input logic [2:0] amt);
    change_valid = 1'b1;
    change       = amt;
    @(negedge clk);
    change_valid = 1'b0;
    change       = 3'd0;
  endtask

  task automatic serve_coin(input string tag, input logic [1:0] exp, input int delay);
    int n = 0;
    while (hop_req == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_req"}, hop_req, exp);
    repeat (delay) @(negedge clk);
    hop_ack = 1'b1;
    @(negedge clk);
    hop_ack = 1'b0;
    check_val({tag, "_drop"}, hop_req, 2'b00);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int nz;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_hop_req", hop_req, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_flags", {done, owed, err_short, err_timeout, pend_ovf}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 3 units with both tubes full: big coin then unit coin
    strobe(3'd3);
    check_val("t1_busy", busy, 1'b1);
    check_val("t1_req_lat", hop_req, 2'b00);
    @(negedge clk);
    check_val("t1_req_big", hop_req, 2'b10);
    hop_ack = 1'b1;
    @(negedge clk);
    hop_ack = 1'b0;
    check_val("t1_req_drop", hop_req, 2'b00);
    @(negedge clk);
    check_val("t1_req_unit", hop_req, 2'b01);
    hop_ack = 1'b1;
    @(negedge clk);
    hop_ack = 1'b0;
    @(negedge clk);
    check_val("t1_done", done, 1'b1);
    check_val("t1_owed", owed, 3'd0);
    @(negedge clk);
    check_val("t1_done_pulse", done, 1'b0);
    check_val("t1_idle", busy, 1'b0);

    // zero change: straight to done, no coin
    strobe(3'd0);
    check_val("t0_done", done, 1'b1);
    check_val("t0_no_req", hop_req, 2'b00);
    @(negedge clk);
    check_val("t0_done_pulse", done, 1'b0);

    // 5 units, big tube empty: five unit coins
    tube_empty = 2'b10;
    strobe(3'd5);
    for (int i = 0; i < 5; i++) serve_coin("t2_coin", 2'b01, 1);
    wait_done("t2");
    check_val("t2_err_short", err_short, 1'b0);
    check_val("t2_owed", owed, 3'd0);

    // 3 units, unit tube empty: one big coin then shortfall of 1
    tube_empty = 2'b01;
    @(negedge clk);
    strobe(3'd3);
    serve_coin("t3_coin", 2'b10, 1);
    nz = 0;
    while (busy && nz < 20) begin
      @(negedge clk);
      nz++;
    end
    check_val("t3_busy", busy, 1'b0);
    check_val("t3_err_short", err_short, 1'b1);
    check_val("t3_owed", owed, 3'd1);
    check_val("t3_hop_req", hop_req, 2'b00);
    repeat (3) @(negedge clk);
    check_val("t3_sticky", err_short, 1'b1);

    // pending entry and overflow
    tube_empty = 2'b00;
    strobe(3'd2);
    check_val("t4_err_cleared", {err_short, owed}, 0);
    strobe(3'd4);
    check_val("t4_no_ovf", pend_ovf, 1'b0);
    strobe(3'd1);
    check_val("t4_ovf", pend_ovf, 1'b1);
    @(negedge clk);
    check_val("t4_ovf_pulse", pend_ovf, 1'b0);
    serve_coin("t4_first", 2'b10, 1);
    wait_done("t4a");
    serve_coin("t4_pend1", 2'b10, 1);
    serve_coin("t4_pend2", 2'b10, 1);
    wait_done("t4b");
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hop_req != 2'b00 || busy) nz++;
    end
    check_val("t4_dropped_never_paid", nz, 0);

    // hopper never acknowledges
    strobe(3'd2);
    @(negedge clk);
    check_val("t5_req", hop_req, 2'b10);
`ifdef VEND_CHANGE_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check_val("t5_pre_expiry", {err_timeout, hop_req}, {1'b0, 2'b10});
    @(negedge clk);
    check_val("t5_err_timeout", err_timeout, 1'b1);
    check_val("t5_owed", owed, 3'd2);
    check_val("t5_hop_req", hop_req, 2'b00);
    @(negedge clk);
    check_val("t5_idle", busy, 1'b0);
`else
    repeat (100) @(negedge clk);
    check_val("t5_still_req", hop_req, 2'b10);
    check_val("t5_no_timeout", err_timeout, 1'b0);
    serve_coin("t5_late", 2'b10, 0);
    wait_done("t5");
`endif

    // reset during WAIT_ACK with a pending entry
    @(negedge clk);
    strobe(3'd3);
    strobe(3'd4);
    check_val("t6_req", hop_req, 2'b10);
    #2 rst = 1'b0;
    #1;
    check_val("t6_rst_req", hop_req, 2'b00);
    check_val("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hop_req != 2'b00 || busy || done) nz++;
    end
    check_val("t6_no_pending", nz, 0);
    check_val("t6_flags", {owed, err_short, err_timeout}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
